// File: rtl/sram_like_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter_pkg
// Shared definitions for the sram-like bus arbiter and its ID FIFO:
//   - SRAM_SIZE_* encodings of the 2-bit size field
//   - lock_state_e : grant lock state of the arbiter
//   - id_width()   : width of a channel ID, clog2(n) with a floor of 1 bit
// -----------------------------------------------------------------------------
package sram_like_arbiter_pkg;

    localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

    // A single channel still needs a 1-bit ID so the FIFO has a real width.
    function automatic int id_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// -----------------------------------------------------------------------------
// arb_id_fifo
// Synchronous in-order FIFO holding channel IDs of outstanding transactions.
// A push and a pop in the same cycle are both honoured, including when the
// FIFO is full (the slot being popped is the one overwritten at the edge).
//
// Ports:
//   clk, resetn    clock, synchronous active-low reset
//   push, din      write din at the tail
//   pop            drop the head entry (ignored when empty)
//   full, empty    occupancy flags
//   head           entry at the read pointer, valid when !empty
// -----------------------------------------------------------------------------
module arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
// Merges NUM_CH sram-like masters onto one sram-like slave. Requests are
// arbitrated round-robin (RR_MODE=1) or fixed priority, highest index wins
// (RR_MODE=0). Channel IDs of accepted requests are queued in order so each
// data_ok/rdata is routed back to the channel that issued it.
//
// Lock state machine:
//   state          | meaning
//   LOCK_UNLOCKED  | grant follows the arbiter every cycle
//   LOCK_LOCKED    | slave stalled a request; grant frozen on lock_ch until
//                  | the slave accepts it
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   up_req/up_wr                per-channel request and write flag
//   up_size                     per-channel size, channel i at [2i+1:2i]
//   up_wstrb/up_addr/up_wdata   per-channel packed payload
//   up_addr_ok/up_data_ok       per-channel handshake returns
//   up_rdata                    read data, broadcast to all channels
//   dn_*                        downstream sram-like slave interface
// -----------------------------------------------------------------------------
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4,
    parameter int RR_MODE = 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_CH-1:0]              up_req,
    input  logic [NUM_CH-1:0]              up_wr,
    input  logic [2*NUM_CH-1:0]            up_size,
    input  logic [(DATA_W/8)*NUM_CH-1:0]   up_wstrb,
    input  logic [ADDR_W*NUM_CH-1:0]       up_addr,
    input  logic [DATA_W*NUM_CH-1:0]       up_wdata,
    output logic [NUM_CH-1:0]              up_addr_ok,
    output logic [NUM_CH-1:0]              up_data_ok,
    output logic [DATA_W-1:0]              up_rdata,
    output logic                           dn_req,
    output logic                           dn_wr,
    output logic [1:0]                     dn_size,
    output logic [DATA_W/8-1:0]            dn_wstrb,
    output logic [ADDR_W-1:0]              dn_addr,
    output logic [DATA_W-1:0]              dn_wdata,
    input  logic                           dn_addr_ok,
    input  logic                           dn_data_ok,
    input  logic [DATA_W-1:0]              dn_rdata
);

    localparam int ID_W   = id_width(NUM_CH);
    localparam int STRB_W = DATA_W / 8;

    lock_state_e       lock_state;
    logic [ID_W-1:0]   lock_ch;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   arb_ch;
    logic [ID_W-1:0]   grant;
    logic [ID_W:0]     cand;
    logic              found;
    logic              fire;
    logic              resp_fire;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ID_W-1:0]   fifo_head;

    logic [ADDR_W-1:0] ch_addr  [NUM_CH];
    logic [DATA_W-1:0] ch_wdata [NUM_CH];
    logic [STRB_W-1:0] ch_wstrb [NUM_CH];
    logic [1:0]        ch_size  [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign ch_addr[c]  = up_addr[c*ADDR_W +: ADDR_W];
        assign ch_wdata[c] = up_wdata[c*DATA_W +: DATA_W];
        assign ch_wstrb[c] = up_wstrb[c*STRB_W +: STRB_W];
        assign ch_size[c]  = up_size[2*c +: 2];
    end

    // Arbiter. In round-robin mode the candidate index is rr_ptr+k folded
    // back into 0..NUM_CH-1, so non-power-of-two channel counts also work.
    always_comb begin
        arb_ch = '0;
        found  = 1'b0;
        cand   = '0;
        if (RR_MODE != 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
                if (cand >= (ID_W+1)'(NUM_CH)) begin
                    cand = cand - (ID_W+1)'(NUM_CH);
                end
                if (!found && up_req[cand[ID_W-1:0]]) begin
                    arb_ch = cand[ID_W-1:0];
                    found  = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (up_req[ID_W'(k)]) begin
                    arb_ch = ID_W'(k);
                end
            end
        end
    end

    assign grant = (lock_state == LOCK_LOCKED) ? lock_ch : arb_ch;

    // Masking by full keeps a stalled master waiting; the lock is untouched.
    assign dn_req    = up_req[grant] & ~fifo_full;
    assign dn_wr     = up_wr[grant];
    assign dn_size   = ch_size[grant];
    assign dn_wstrb  = ch_wstrb[grant];
    assign dn_addr   = ch_addr[grant];
    assign dn_wdata  = ch_wdata[grant];

    assign fire      = dn_req & dn_addr_ok;
    // A data_ok with nothing outstanding is a slave protocol error; drop it.
    assign resp_fire = dn_data_ok & ~fifo_empty;

    always_comb begin
        up_addr_ok        = '0;
        up_addr_ok[grant] = fire;
    end

    always_comb begin
        up_data_ok            = '0;
        up_data_ok[fifo_head] = resp_fire;
    end

    assign up_rdata = dn_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_state <= LOCK_UNLOCKED;
            lock_ch    <= '0;
            rr_ptr     <= '0;
        end else begin
            case (lock_state)
                LOCK_UNLOCKED: begin
                    if (dn_req && !dn_addr_ok) begin
                        lock_state <= LOCK_LOCKED;
                        lock_ch    <= grant;
                    end
                end
                LOCK_LOCKED: begin
                    if (fire) begin
                        lock_state <= LOCK_UNLOCKED;
                    end
                end
                default: lock_state <= LOCK_UNLOCKED;
            endcase
            if (RR_MODE != 0 && fire) begin
                rr_ptr <= (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUT),
        .W     (ID_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fire),
        .pop    (resp_fire),
        .din    (grant),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_like_arbiter
// Directed bench for sram_like_arbiter: one round-robin instance (dut) and
// one fixed-priority instance (fdut) sharing clock, reset and payload inputs.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// -----------------------------------------------------------------------------
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h1C00_0000;
    localparam logic [31:0] W0 = 32'h1111_1111;
    localparam logic [31:0] W1 = 32'h2222_2222;

    logic        clk;
    logic        resetn;
    logic [1:0]  up_req;
    logic [1:0]  up_wr;
    logic [3:0]  up_size;
    logic [7:0]  up_wstrb;
    logic [63:0] up_addr;
    logic [63:0] up_wdata;
    logic [1:0]  up_addr_ok;
    logic [1:0]  up_data_ok;
    logic [31:0] up_rdata;
    logic        dn_req;
    logic        dn_wr;
    logic [1:0]  dn_size;
    logic [3:0]  dn_wstrb;
    logic [31:0] dn_addr;
    logic [31:0] dn_wdata;
    logic        dn_addr_ok;
    logic        dn_data_ok;
    logic [31:0] dn_rdata;

    logic [1:0]  f_req;
    logic [1:0]  f_addr_ok;
    logic [1:0]  f_data_ok;
    logic [31:0] f_rdata_up;
    logic        f_dn_req;
    logic        f_dn_wr;
    logic [1:0]  f_dn_size;
    logic [3:0]  f_dn_wstrb;
    logic [31:0] f_dn_addr;
    logic [31:0] f_dn_wdata;
    logic        f_dn_addr_ok;
    logic        f_dn_data_ok;
    logic [31:0] f_dn_rdata;

    int errors = 0;
    int checks = 0;

    sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUT(4), .RR_MODE(1)) dut (
        .clk(clk), .resetn(resetn),
        .up_req(up_req), .up_wr(up_wr), .up_size(up_size), .up_wstrb(up_wstrb),
        .up_addr(up_addr), .up_wdata(up_wdata),
        .up_addr_ok(up_addr_ok), .up_data_ok(up_data_ok), .up_rdata(up_rdata),
        .dn_req(dn_req), .dn_wr(dn_wr), .dn_size(dn_size), .dn_wstrb(dn_wstrb),
        .dn_addr(dn_addr), .dn_wdata(dn_wdata),
        .dn_addr_ok(dn_addr_ok), .dn_data_ok(dn_data_ok), .dn_rdata(dn_rdata)
    );

    sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUT(4), .RR_MODE(0)) fdut (
        .clk(clk), .resetn(resetn),
        .up_req(f_req), .up_wr(up_wr), .up_size(up_size), .up_wstrb(up_wstrb),
        .up_addr(up_addr), .up_wdata(up_wdata),
        .up_addr_ok(f_addr_ok), .up_data_ok(f_data_ok), .up_rdata(f_rdata_up),
        .dn_req(f_dn_req), .dn_wr(f_dn_wr), .dn_size(f_dn_size), .dn_wstrb(f_dn_wstrb),
        .dn_addr(f_dn_addr), .dn_wdata(f_dn_wdata),
        .dn_addr_ok(f_dn_addr_ok), .dn_data_ok(f_dn_data_ok), .dn_rdata(f_dn_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream and slave protocol rules.
    always @(posedge clk) begin
        if (resetn) begin
            if (dut.lock_state == LOCK_LOCKED)
                assert (up_req[dut.lock_ch]) else $error("up_req dropped while locked");
            assert (!(dn_data_ok && dut.u_fifo.empty)) else $error("dn_data_ok with nothing outstanding");
            assert (!(f_dn_data_ok && fdut.u_fifo.empty)) else $error("fixed dn_data_ok with nothing outstanding");
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] req, input logic aok, input logic dok, input logic [31:0] rd);
        @(negedge clk);
        up_req     = req;
        dn_addr_ok = aok;
        dn_data_ok = dok;
        dn_rdata   = rd;
        #1;
    endtask

    task automatic fcyc(input logic [1:0] req, input logic aok, input logic dok, input logic [31:0] rd);
        @(negedge clk);
        f_req        = req;
        f_dn_addr_ok = aok;
        f_dn_data_ok = dok;
        f_dn_rdata   = rd;
        #1;
    endtask

    initial begin
        logic [1:0] exp_oh;

        resetn       = 1'b0;
        up_req       = '0;
        up_wr        = '0;
        up_size      = {SRAM_SIZE_BYTE, SRAM_SIZE_WORD};
        up_wstrb     = {4'b0001, 4'b1111};
        up_addr      = {A1, A0};
        up_wdata     = {W1, W0};
        dn_addr_ok   = 1'b0;
        dn_data_ok   = 1'b0;
        dn_rdata     = '0;
        f_req        = '0;
        f_dn_addr_ok = 1'b0;
        f_dn_data_ok = 1'b0;
        f_dn_rdata   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        cyc(2'b00, 1'b0, 1'b0, 32'h0);
        chk("rst_dn_req", dn_req, 0);
        chk("rst_addr_ok", up_addr_ok, 0);
        chk("rst_data_ok", up_data_ok, 0);
        chk("rst_count", dut.u_fifo.count, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Single read on ch1, data_ok two cycles after the accept
        cyc(2'b10, 1'b1, 1'b0, 32'h0);
        chk("rd1_dn_req", dn_req, 1);
        chk("rd1_dn_addr", dn_addr, A1);
        chk("rd1_addr_ok", up_addr_ok, 2'b10);
        cyc(2'b00, 1'b0, 1'b0, 32'h0);
        chk("rd1_addr_ok_pulse", up_addr_ok, 0);
        chk("rd1_no_data_yet", up_data_ok, 0);
        cyc(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("rd1_data_ok", up_data_ok, 2'b10);
        chk("rd1_rdata", up_rdata, 32'hDEAD_BEEF);
        cyc(2'b00, 1'b0, 1'b0, 32'h0);
        chk("rd1_data_ok_pulse", up_data_ok, 0);
        chk("rd1_count", dut.u_fifo.count, 0);

        // Round robin alternation until the FIFO fills
        for (int i = 0; i < 4; i++) begin
            cyc(2'b11, 1'b1, 1'b0, 32'h0);
            chk("rr_addr_ok", up_addr_ok, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_dn_addr", dn_addr, (i % 2 == 0) ? A0 : A1);
        end
        cyc(2'b11, 1'b1, 1'b0, 32'h0);
        chk("full_dn_req", dn_req, 0);
        chk("full_addr_ok", up_addr_ok, 0);
        chk("full_count", dut.u_fifo.count, 4);
        cyc(2'b11, 1'b0, 1'b1, 32'h0000_1111);
        chk("full_pop_data_ok", up_data_ok, 2'b01);
        chk("full_pop_dn_req", dn_req, 0);
        chk("full_pop_rdata", up_rdata, 32'h0000_1111);
        cyc(2'b11, 1'b1, 1'b0, 32'h0);
        chk("refill_dn_req", dn_req, 1);
        chk("refill_addr_ok", up_addr_ok, 2'b01);
        for (int i = 0; i < 4; i++) begin
            cyc(2'b00, 1'b0, 1'b1, 32'h0000_2000 + i);
            chk("order_data_ok", up_data_ok, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("order_rdata", up_rdata, 32'h0000_2000 + i);
        end
        cyc(2'b00, 1'b0, 1'b0, 32'h0);
        chk("order_drained", dut.u_fifo.count, 0);

        // Lock: rr_ptr points at ch1, ch0 is stalled, ch1 arrives later
        cyc(2'b01, 1'b0, 1'b0, 32'h0);
        chk("lock_dn_req", dn_req, 1);
        chk("lock_addr0", dn_addr, A0);
        for (int i = 0; i < 2; i++) begin
            cyc(2'b11, 1'b0, 1'b0, 32'h0);
            chk("lock_hold_addr", dn_addr, A0);
            chk("lock_hold_addr_ok", up_addr_ok, 0);
        end
        cyc(2'b11, 1'b1, 1'b0, 32'h0);
        chk("lock_accept_addr", dn_addr, A0);
        chk("lock_accept_ok", up_addr_ok, 2'b01);
        cyc(2'b11, 1'b1, 1'b0, 32'h0);
        chk("lock_next_addr", dn_addr, A1);
        chk("lock_next_ok", up_addr_ok, 2'b10);

        // Push and pop together at count=2, pointers wrapping
        for (int i = 0; i < 10; i++) begin
            exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            cyc(2'b11, 1'b1, 1'b1, 32'hA000_0000 + i);
            chk("pp_count", dut.u_fifo.count, 2);
            chk("pp_addr_ok", up_addr_ok, exp_oh);
            chk("pp_data_ok", up_data_ok, exp_oh);
            chk("pp_rdata", up_rdata, 32'hA000_0000 + i);
        end
        cyc(2'b00, 1'b0, 1'b0, 32'h0);
        chk("pp_count_end", dut.u_fifo.count, 2);
        chk("pp_wr_ptr", dut.u_fifo.wr_ptr, 2);
        chk("pp_rd_ptr", dut.u_fifo.rd_ptr, 0);

        // Reset with 3 outstanding and ch1 locked
        cyc(2'b01, 1'b1, 1'b0, 32'h0);
        chk("pre_rst_addr_ok", up_addr_ok, 2'b01);
        cyc(2'b10, 1'b0, 1'b0, 32'h0);
        chk("pre_rst_dn_addr", dn_addr, A1);
        @(negedge clk);
        resetn = 1'b0;
        chk("pre_rst_count", dut.u_fifo.count, 3);
        chk("pre_rst_locked", dut.lock_state, LOCK_LOCKED);
        @(negedge clk);
        resetn = 1'b1;
        up_req = 2'b00;
        #1;
        chk("post_rst_count", dut.u_fifo.count, 0);
        chk("post_rst_unlocked", dut.lock_state, LOCK_UNLOCKED);
        chk("post_rst_dn_req", dn_req, 0);
        up_wr = 2'b01;
        cyc(2'b11, 1'b1, 1'b0, 32'h0);
        chk("wr_addr_ok", up_addr_ok, 2'b01);
        chk("wr_dn_wr", dn_wr, 1);
        chk("wr_dn_addr", dn_addr, A0);
        chk("wr_dn_wdata", dn_wdata, W0);
        chk("wr_dn_wstrb", dn_wstrb, 4'b1111);
        chk("wr_dn_size", dn_size, SRAM_SIZE_WORD);
        up_wr = 2'b00;
        cyc(2'b00, 1'b0, 1'b1, 32'h0);
        chk("wr_data_ok", up_data_ok, 2'b01);
        cyc(2'b00, 1'b0, 1'b0, 32'h0);
        chk("wr_data_ok_pulse", up_data_ok, 0);

        // Fixed priority: ch1 wins every cycle, ch0 starves
        for (int i = 0; i < 4; i++) begin
            fcyc(2'b11, 1'b1, (i > 0), 32'hB000_0000 + i);
            chk("fix_addr_ok", f_addr_ok, 2'b10);
            chk("fix_dn_addr", f_dn_addr, A1);
            chk("fix_dn_size", f_dn_size, SRAM_SIZE_BYTE);
            chk("fix_data_ok", f_data_ok, (i > 0) ? 2'b10 : 2'b00);
        end
        fcyc(2'b00, 1'b0, 1'b1, 32'hB000_0010);
        chk("fix_last_data_ok", f_data_ok, 2'b10);
        chk("fix_last_rdata", f_rdata_up, 32'hB000_0010);
        fcyc(2'b00, 1'b0, 1'b0, 32'h0);
        chk("fix_idle_data_ok", f_data_ok, 0);
        chk("fix_count", fdut.u_fifo.count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Parametrised N-channel arbiter for the sram-like request/addr_ok/data_ok bus.
- Merges NUM_CH upstream masters onto one downstream sram-like slave. Typical upstream masters are the core's inst and data ports, or extra masters added later.
- Tracks outstanding transactions in an in-order ID FIFO and routes each data_ok/rdata back to the channel that issued the request.
- Sits between the core and the AXI bridge / SoC SRAM.

Parameters:
NUM_CH, 2, number of upstream channels (>=2); channel index = priority rank in fixed mode
ADDR_W, 32, address width
DATA_W, 32, data width; wstrb width = DATA_W/8
MAX_OUT, 4, max outstanding downstream transactions (power of 2, >=2)
RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority with highest index winning

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
up_req  in  NUM_CH  per-channel request
up_wr  in  NUM_CH  per-channel write flag
up_size  in  2*NUM_CH  per-channel size, channel i at [2i+1:2i]
up_wstrb  in  (DATA_W/8)*NUM_CH  per-channel byte strobes
up_addr  in  ADDR_W*NUM_CH  per-channel address
up_wdata  in  DATA_W*NUM_CH  per-channel write data
up_addr_ok  out  NUM_CH  per-channel request accepted
up_data_ok  out  NUM_CH  per-channel response
up_rdata  out  DATA_W  read data, broadcast; valid for the channel whose up_data_ok is high
dn_req  out  1  downstream request
dn_wr  out  1  downstream write flag
dn_size  out  2  downstream size
dn_wstrb  out  DATA_W/8  downstream strobes
dn_addr  out  ADDR_W  downstream address
dn_wdata  out  DATA_W  downstream write data
dn_addr_ok  in  1  downstream accept
dn_data_ok  in  1  downstream response
dn_rdata  in  DATA_W  downstream read data

Behaviour:
- Decided: one clock, clk; reset resetn is synchronous and active-low.
- Reset values:
  - ID FIFO empty; rd_ptr, wr_ptr and count = 0.
  - Lock cleared; rr_ptr = 0.
  - All outputs are combinational from state and inputs, so after reset dn_req = 0, up_addr_ok = 0 and up_data_ok = 0 unless the inputs drive them.
- Full condition: full = (count == MAX_OUT).
- Arbitration, when unlocked:
  - RR_MODE = 1: the winner is the first requesting channel searching from rr_ptr upward, modulo NUM_CH.
  - RR_MODE = 0: the winner is the highest requesting index.
- Lock state machine, states UNLOCKED and LOCKED(g):
  - UNLOCKED -> LOCKED(g) when dn_req = 1 and dn_addr_ok = 0.
  - LOCKED(g) -> UNLOCKED on dn_addr_ok = 1.
  - While LOCKED the grant stays on g regardless of other requests, so the downstream address and data never change mid-handshake.
- Downstream request: dn_req = (granted channel's up_req) & ~full. dn_wr, dn_size, dn_wstrb, dn_addr and dn_wdata are muxed from the granted channel.
- Accept: up_addr_ok[g] = dn_req & dn_addr_ok; all other up_addr_ok bits are 0.
- Handshake fire, when dn_req & dn_addr_ok:
  - Push g into FIFO[wr_ptr]; wr_ptr++ with wrap modulo MAX_OUT.
  - If RR_MODE, rr_ptr = g+1 modulo NUM_CH.
- Response:
  - On dn_data_ok with count > 0: up_data_ok[FIFO[rd_ptr]] = 1, up_rdata = dn_rdata; pop, rd_ptr++ with wrap.
  - Writes also receive a data_ok.
- Latency:
  - Zero-cycle combinational pass-through for both addr_ok and data_ok.
  - Downstream data_ok never arrives in the same cycle as its own addr_ok.
- Simultaneous push and pop: count unchanged; both pointers advance. This is legal even when full, because the pop frees the slot only next cycle; dn_req is still masked by full in that cycle.
- Empty: dn_data_ok with count == 0 is a protocol error. No up_data_ok is generated and state is unchanged; the bench flags it with an assertion.
- Full: dn_req is held 0 and up_req waits. A channel that is LOCKED stays locked.
- A channel may drop up_req while unlocked; it is ignored. It must not drop while LOCKED (upstream protocol); this is checked by an assertion.
- Reset mid-operation flushes the FIFO and lock. The downstream slave shares resetn, so no stale data_ok follows.

Decomposition:
- Shared package holds:
  - SRAM_SIZE_BYTE/HALF/WORD encodings (0/1/2).
  - The lock state enum.
  - An id-width function clog2(NUM_CH).
- Sub-module arb_id_fifo (params DEPTH, W): sync FIFO with push, pop, full, empty and head, handling simultaneous push and pop. It is reused later by the AXI bridge.

Test Plan:
- Single read, ch1 addr 0x1C00_0000, slave addr_ok same cycle, data_ok +2 cycles with 0xDEAD_BEEF -> up_addr_ok[1] pulses once, up_data_ok[1] = 1 with up_rdata = 0xDEAD_BEEF two cycles later, ch0 sees nothing.
- Both channels request every cycle, RR_MODE=1, addr_ok always 1 -> grants alternate 0,1,0,1; with RR_MODE=0, ch1 wins every cycle and ch0 starves.
- Slave withholds addr_ok 3 cycles while ch0 is locked and ch1 raises req -> dn_addr stays ch0's value all 3 cycles; ch1 is granted the cycle after the accept.
- Issue 4 reads with data_ok withheld (MAX_OUT=4) -> 5th req sees dn_req = 0. The first data_ok pops and dn_req reasserts the next cycle; responses return in issue order with ch IDs 0,1,0,1.
- Push and pop in the same cycle at count=2 -> count stays 2, pointers wrap correctly across index 3→0 over 10 transactions.
- resetn low for one cycle with 3 outstanding -> next cycle count = 0, unlocked; a subsequent single write to ch0 gets up_addr_ok and up_data_ok normally.
